// File: rtl/clk_div_sched.sv
// Divided-clock sequencer: programmable ratio, two-requester valid/ready update path, glitch-free
// ratio changes at period boundaries. Define CLK_DIV_SCHED_REQ1_EN to build in requester 1 + RR.
module clk_div_sched #(
    parameter int unsigned DIV_W    = 8,
    parameter int unsigned DIV_INIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             req0_valid,
    input  logic [DIV_W-1:0] req0_div,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [DIV_W-1:0] req1_div,
    output logic             req1_ready,
    output logic             o_clk,
    output logic [DIV_W-1:0] cur_div,
    output logic             busy,
    output logic             err
);

    typedef enum logic [1:0] {StIdle, StRun, StStop} state_e;

    localparam logic [DIV_W-1:0] One     = DIV_W'(1);
    localparam logic [DIV_W-1:0] Two     = DIV_W'(2);
    localparam logic [DIV_W-1:0] InitDiv = DIV_W'(DIV_INIT);

    state_e           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] cur_div_q, cur_div_d;
    logic [DIV_W-1:0] slot_div_q, slot_div_d;
    logic             slot_valid_q, slot_valid_d;
    logic             o_clk_q, o_clk_d;
    logic             err_q, err_d;

    logic             grant0, grant1;
    logic             xfer0, xfer1, xfer;
    logic [DIV_W-1:0] sel_div;
    logic             boundary;

`ifdef CLK_DIV_SCHED_REQ1_EN
    // rr_q: 0 favours requester 0 on a tie, 1 favours requester 1.
    logic rr_q, rr_d;

    always_comb begin
        grant0 = req0_valid && (!req1_valid || !rr_q);
        grant1 = req1_valid && (!req0_valid || rr_q);
    end

    always_comb begin
        rr_d = rr_q;
        if (xfer0) begin
            rr_d = 1'b1;
        end else if (xfer1) begin
            rr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    logic unused_req1;

    assign unused_req1 = req1_valid ^ (^req1_div);
    assign grant0      = 1'b1;
    assign grant1      = 1'b0;
`endif

    assign req0_ready = grant0 && !slot_valid_q;
    assign req1_ready = grant1 && !slot_valid_q;
    assign xfer0      = req0_valid && req0_ready;
    assign xfer1      = req1_valid && req1_ready;
    assign xfer       = xfer0 || xfer1;
    assign sel_div    = xfer1 ? req1_div : req0_div;

    assign boundary   = (state_q != StIdle) && (cnt_q == cur_div_q - One);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (en) state_d = StRun;
            StRun:  if (!en) state_d = StStop;
            StStop: begin
                if (en) begin
                    state_d = StRun;
                end else if (boundary) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_d        = '0;
        cur_div_d    = cur_div_q;
        slot_div_d   = slot_div_q;
        slot_valid_d = slot_valid_q;
        err_d        = 1'b0;

        if (state_q != StIdle && !boundary) begin
            cnt_d = cnt_q + One;
        end

        // Idle has no period to protect, so a pending ratio lands immediately.
        if (slot_valid_q && (state_q == StIdle || boundary)) begin
            cur_div_d    = slot_div_q;
            slot_valid_d = 1'b0;
        end

        // Ready is low while the slot is full, so this never collides with the load above.
        if (xfer) begin
            if (sel_div >= Two) begin
                slot_valid_d = 1'b1;
                slot_div_d   = sel_div;
            end else begin
                err_d = 1'b1;
            end
        end

        o_clk_d = (cnt_d >= (cur_div_d >> 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            cur_div_q    <= InitDiv;
            slot_div_q   <= '0;
            slot_valid_q <= 1'b0;
            o_clk_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cur_div_q    <= cur_div_d;
            slot_div_q   <= slot_div_d;
            slot_valid_q <= slot_valid_d;
            o_clk_q      <= o_clk_d;
            err_q        <= err_d;
        end
    end

    assign o_clk   = o_clk_q;
    assign cur_div = cur_div_q;
    assign busy    = (state_q != StIdle);
    assign err     = err_q;

endmodule
